// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI-lite bus bundle between one master and one slave
interface axi_lite_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    modport master (
        output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        input  arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
    modport slave (
        input  arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wmask, bready,
        output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp
    );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// axi_lite_sram_slave: AXI-lite responder for a word-addressed SRAM with fixed plus optional LFSR-jittered latency
module axi_lite_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH      = 1024,
    parameter int          RD_LAT     = 1,
    parameter int          WR_LAT     = 1,
    parameter int          RAND_DELAY = 0,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input logic       clk,
    input logic       rst_n,
    axi_lite_if.slave s
);
    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;
    state_t      state_q, state_d;
    logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic [31:0] cnt_q, cnt_d, araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        rvalid_q, rvalid_d, bvalid_q, bvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d, bresp_q, bresp_d;
    logic [31:0] mem [DEPTH];
    logic [31:0] rd_off, wr_off, extra;
    logic        rd_in, wr_in, idle, ar_hs, aw_hs, w_hs, commit;
    logic        unused_bits;
    assign idle      = state_q == IDLE;
    // a read only wins when no half of a write is already captured
    assign s.arready = rst_n && idle && !aw_got_q && !w_got_q;
    assign s.awready = rst_n && idle && !aw_got_q && !(s.arvalid && !w_got_q);
    assign s.wready  = rst_n && idle && !w_got_q && !(s.arvalid && !aw_got_q);
    assign ar_hs     = s.arvalid && s.arready;
    assign aw_hs     = s.awvalid && s.awready;
    assign w_hs      = s.wvalid && s.wready;
    assign rd_off    = araddr_q - BASE_ADDR;
    assign wr_off    = awaddr_q - BASE_ADDR;
    assign rd_in     = rd_off < SPAN;
    assign wr_in     = wr_off < SPAN;
    assign extra     = RAND_DELAY != 0 ? {28'd0, lfsr_q[3:0]} : 32'd0;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;
    assign s.bvalid  = bvalid_q;
    assign s.bresp   = bresp_q;
    assign unused_bits = ^s.wmask[7:4];
    always_comb begin
        state_d  = state_q;
        aw_got_d = aw_got_q || aw_hs;
        w_got_d  = w_got_q || w_hs;
        cnt_d    = cnt_q;
        araddr_d = ar_hs ? s.araddr : araddr_q;
        awaddr_d = aw_hs ? s.awaddr : awaddr_q;
        wdata_d  = w_hs ? s.wdata : wdata_q;
        wmask_d  = w_hs ? s.wmask[3:0] : wmask_q;
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        commit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    cnt_d   = 32'(RD_LAT - 1) + extra;
                    state_d = RD_WAIT;
                end else if (aw_got_q && w_got_q) begin
                    cnt_d   = 32'(WR_LAT - 1) + extra;
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == '0) begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = rd_in ? mem[rd_off[IW+1:2]] : '0;
                    rresp_d  = rd_in ? 2'b00 : 2'b10;
                end
            end
            RD_RESP: begin
                rvalid_d = !s.rready;
                state_d  = s.rready ? IDLE : RD_RESP;
            end
            WR_WAIT: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == '0) begin
                    commit   = rst_n && wr_in;
                    state_d  = WR_RESP;
                    bvalid_d = 1'b1;
                    bresp_d  = wr_in ? 2'b00 : 2'b10;
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                end
            end
            WR_RESP: begin
                bvalid_d = !s.bready;
                state_d  = s.bready ? IDLE : WR_RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            cnt_q    <= '0;
            araddr_q <= '0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            lfsr_q   <= LFSR_SEED;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= '0;
        end else begin
            state_q  <= state_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
            awaddr_q <= awaddr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            lfsr_q   <= lfsr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end
    always_ff @(posedge clk) begin
        if (commit)
            for (int i = 0; i < 4; i++)
                if (wmask_q[i]) mem[wr_off[IW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb_axi_lite_sram_slave: directed and randomized checks of the AXI-lite SRAM slave against a word-array model
module tb_axi_lite_sram_slave;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int R_RD = 2;
    localparam int R_WR = 3;
    logic        clk = 0, rst_n = 0;
    bit          sel = 0;
    logic        arvalid = 0, rready = 0, awvalid = 0, wvalid = 0, bready = 0;
    logic [31:0] araddr = 0, awaddr = 0, wdata = 0;
    logic [7:0]  wmask = 0;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp, bresp;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] mdl [1024];
    axi_lite_if a();
    axi_lite_if r();
    axi_lite_sram_slave u_fix (.clk(clk), .rst_n(rst_n), .s(a));
    axi_lite_sram_slave #(.RD_LAT(R_RD), .WR_LAT(R_WR), .RAND_DELAY(1)) u_rnd (.clk(clk), .rst_n(rst_n), .s(r));
    // sel steers the shared master signals to one of the two slaves
    assign a.arvalid = arvalid && !sel;
    assign r.arvalid = arvalid && sel;
    assign a.awvalid = awvalid && !sel;
    assign r.awvalid = awvalid && sel;
    assign a.wvalid  = wvalid && !sel;
    assign r.wvalid  = wvalid && sel;
    assign a.araddr  = araddr;
    assign r.araddr  = araddr;
    assign a.awaddr  = awaddr;
    assign r.awaddr  = awaddr;
    assign a.wdata   = wdata;
    assign r.wdata   = wdata;
    assign a.wmask   = wmask;
    assign r.wmask   = wmask;
    assign a.rready  = rready;
    assign r.rready  = rready;
    assign a.bready  = bready;
    assign r.bready  = bready;
    assign arready = sel ? r.arready : a.arready;
    assign awready = sel ? r.awready : a.awready;
    assign wready  = sel ? r.wready : a.wready;
    assign rvalid  = sel ? r.rvalid : a.rvalid;
    assign rdata   = sel ? r.rdata : a.rdata;
    assign rresp   = sel ? r.rresp : a.rresp;
    assign bvalid  = sel ? r.bvalid : a.bvalid;
    assign bresp   = sel ? r.bresp : a.bresp;
    always #5 clk = ~clk;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic start_read(input logic [31:0] addr, output bit ok);
        int n = 0;
        @(negedge clk);
        araddr = addr;
        arvalid = 1;
        #1;
        while (!arready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = arready;
        @(negedge clk);
        arvalid = 0;
    endtask
    task automatic start_write(input logic [31:0] addr, input logic [31:0] d, input logic [7:0] m,
                               input int dw, input int da, output bit ok);
        bit aw_d = 0, w_d = 0;
        int n = 0;
        awaddr = addr;
        wdata = d;
        wmask = m;
        while (!(aw_d && w_d) && n < 60) begin
            @(negedge clk);
            awvalid = !aw_d && n >= da;
            wvalid = !w_d && n >= dw;
            #1;
            if (awvalid && awready) aw_d = 1;
            if (wvalid && wready) w_d = 1;
            n++;
        end
        ok = aw_d && w_d;
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
    endtask
    // lat counts falling edges after the last address/data handshake edge
    task automatic wait_valid(input bit rd, output int lat, output bit ok);
        lat = 0;
        while (!(rd ? rvalid : bvalid) && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        ok = rd ? rvalid : bvalid;
    endtask
    task automatic do_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] rsp,
                           output int lat, output bit ok);
        bit ok1, ok2;
        rready = 1;
        start_read(addr, ok1);
        wait_valid(1, lat, ok2);
        ok = ok1 && ok2;
        d = rdata;
        rsp = rresp;
        @(negedge clk);
        rready = 0;
    endtask
    task automatic do_write(input logic [31:0] addr, input logic [31:0] d, input logic [7:0] m,
                            input int dw, input int da, output logic [1:0] rsp, output int lat, output bit ok);
        bit ok1, ok2;
        bready = 1;
        start_write(addr, d, m, dw, da, ok1);
        wait_valid(0, lat, ok2);
        ok = ok1 && ok2;
        rsp = bresp;
        @(negedge clk);
        bready = 0;
    endtask
    task automatic test_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        n_chk++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        n_chk++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL rst_bvalid: got %b want 0", bvalid); end
        n_chk++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_chk++; if (rresp !== 2'b00) begin n_fail++; $display("FAIL rst_rresp: got %b want 00", rresp); end
        n_chk++; if (bresp !== 2'b00) begin n_fail++; $display("FAIL rst_bresp: got %b want 00", bresp); end
        n_chk++; if (arready !== 1'b0) begin n_fail++; $display("FAIL rst_arready: got %b want 0", arready); end
        n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL rst_awready: got %b want 0", awready); end
        n_chk++; if (wready !== 1'b0) begin n_fail++; $display("FAIL rst_wready: got %b want 0", wready); end
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (arready !== 1'b1) begin n_fail++; $display("FAIL idle_arready: got %b want 1", arready); end
        n_chk++; if (awready !== 1'b1) begin n_fail++; $display("FAIL idle_awready: got %b want 1", awready); end
        n_chk++; if (wready !== 1'b1) begin n_fail++; $display("FAIL idle_wready: got %b want 1", wready); end
    endtask
    task automatic test_basic();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        do_write(32'h8000_0010, 32'hDEADBEEF, 8'h0F, 0, 0, rsp, lat, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_wr_done: got timeout want handshake"); end
        n_chk++; if (rsp !== 2'b00) begin n_fail++; $display("FAIL basic_bresp: got %b want 00", rsp); end
        n_chk++; if (lat !== 2) begin n_fail++; $display("FAIL basic_wr_lat: got %0d want 2", lat); end
        do_read(32'h8000_0010, d, rsp, lat, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL basic_rd_done: got timeout want handshake"); end
        n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rdata: got %h want deadbeef", d); end
        n_chk++; if (rsp !== 2'b00) begin n_fail++; $display("FAIL basic_rresp: got %b want 00", rsp); end
        n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL basic_rd_lat: got %0d want 1", lat); end
    endtask
    task automatic test_mask();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        do_write(32'h8000_0020, 32'hDEADBEEF, 8'h0F, 0, 0, rsp, lat, ok);
        do_write(32'h8000_0020, 32'h11223344, 8'h05, 0, 0, rsp, lat, ok);
        do_read(32'h8000_0020, d, rsp, lat, ok);
        n_chk++; if (d !== 32'hDE22BE44) begin n_fail++; $display("FAIL mask_05: got %h want de22be44", d); end
        do_write(32'h8000_0020, 32'hCAFEF00D, 8'hF0, 0, 0, rsp, lat, ok);
        n_chk++; if (rsp !== 2'b00) begin n_fail++; $display("FAIL mask_f0_bresp: got %b want 00", rsp); end
        do_read(32'h8000_0022, d, rsp, lat, ok);
        n_chk++; if (d !== 32'hDE22BE44) begin n_fail++; $display("FAIL mask_f0: got %h want de22be44", d); end
    endtask
    task automatic test_out_of_range();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        do_read(32'h8000_1000, d, rsp, lat, ok);
        n_chk++; if (rsp !== 2'b10) begin n_fail++; $display("FAIL oor_rresp: got %b want 10", rsp); end
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", d); end
        do_write(32'h8000_0FFC, 32'h12345678, 8'h0F, 0, 0, rsp, lat, ok);
        n_chk++; if (rsp !== 2'b00) begin n_fail++; $display("FAIL last_bresp: got %b want 00", rsp); end
        do_write(32'h7FFF_FFFC, 32'hFFFFFFFF, 8'h0F, 0, 0, rsp, lat, ok);
        n_chk++; if (rsp !== 2'b10) begin n_fail++; $display("FAIL oor_bresp: got %b want 10", rsp); end
        do_read(32'h8000_0FFC, d, rsp, lat, ok);
        n_chk++; if (d !== 32'h12345678) begin n_fail++; $display("FAIL oor_untouched: got %h want 12345678", d); end
        n_chk++; if (rsp !== 2'b00) begin n_fail++; $display("FAIL last_rresp: got %b want 00", rsp); end
    endtask
    task automatic test_w_first();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        do_write(32'h8000_0030, 32'hA5A55A5A, 8'h0F, 0, 3, rsp, lat, ok);
        n_chk++; if (!ok || rsp !== 2'b00) begin n_fail++; $display("FAIL wfirst_bresp: got ok=%b resp=%b want ok=1 resp=00", ok, rsp); end
        do_read(32'h8000_0030, d, rsp, lat, ok);
        n_chk++; if (d !== 32'hA5A55A5A) begin n_fail++; $display("FAIL wfirst_rdata: got %h want a5a55a5a", d); end
    endtask
    task automatic test_tie();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat, n;
        bit ok, aw_d, w_d;
        @(negedge clk);
        araddr = 32'h8000_0010;
        awaddr = 32'h8000_0040;
        wdata = 32'h0BADF00D;
        wmask = 8'h0F;
        rready = 1;
        bready = 1;
        arvalid = 1;
        awvalid = 1;
        wvalid = 1;
        #1;
        n_chk++; if (arready !== 1'b1) begin n_fail++; $display("FAIL tie_arready: got %b want 1", arready); end
        n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL tie_awready: got %b want 0", awready); end
        n_chk++; if (wready !== 1'b0) begin n_fail++; $display("FAIL tie_wready: got %b want 0", wready); end
        @(negedge clk);
        arvalid = 0;
        #1;
        n_chk++; if (awready !== 1'b0) begin n_fail++; $display("FAIL tie_busy_awready: got %b want 0", awready); end
        wait_valid(1, lat, ok);
        n_chk++; if (!ok || rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL tie_rdata: got %h want deadbeef", rdata); end
        n_chk++; if (bvalid !== 1'b0) begin n_fail++; $display("FAIL tie_read_first: got bvalid=%b want 0", bvalid); end
        aw_d = 0;
        w_d = 0;
        n = 0;
        while (!(aw_d && w_d) && n < 60) begin
            @(negedge clk);
            awvalid = !aw_d;
            wvalid = !w_d;
            #1;
            if (awvalid && awready) aw_d = 1;
            if (wvalid && wready) w_d = 1;
            n++;
        end
        @(negedge clk);
        awvalid = 0;
        wvalid = 0;
        wait_valid(0, lat, ok);
        n_chk++; if (!ok || bresp !== 2'b00) begin n_fail++; $display("FAIL tie_bresp: got ok=%b resp=%b want ok=1 resp=00", ok, bresp); end
        @(negedge clk);
        rready = 0;
        bready = 0;
        do_read(32'h8000_0040, d, rsp, lat, ok);
        n_chk++; if (d !== 32'h0BADF00D) begin n_fail++; $display("FAIL tie_wr_data: got %h want 0badf00d", d); end
    endtask
    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        rready = 0;
        start_read(32'h8000_0030, ok);
        wait_valid(1, lat, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL bp_rvalid[%0d]: got %b want 1", i, rvalid); end
            n_chk++; if (rdata !== 32'hA5A55A5A || rresp !== 2'b00) begin n_fail++; $display("FAIL bp_rdata[%0d]: got %h/%b want a5a55a5a/00", i, rdata, rresp); end
            n_chk++; if (arready !== 1'b0) begin n_fail++; $display("FAIL bp_arready[%0d]: got %b want 0", i, arready); end
        end
        rready = 1;
        @(negedge clk);
        rready = 0;
        n_chk++; if (rvalid !== 1'b0 || arready !== 1'b1) begin n_fail++; $display("FAIL bp_r_release: got rvalid=%b arready=%b want 0/1", rvalid, arready); end
        n_chk++; if (rdata !== 32'hA5A55A5A) begin n_fail++; $display("FAIL bp_rdata_hold: got %h want a5a55a5a", rdata); end
        bready = 0;
        start_write(32'h8000_0050, 32'h13579BDF, 8'h0F, 0, 0, ok);
        wait_valid(0, lat, ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin n_fail++; $display("FAIL bp_bvalid[%0d]: got %b/%b want 1/00", i, bvalid, bresp); end
            n_chk++; if (awready !== 1'b0 || wready !== 1'b0) begin n_fail++; $display("FAIL bp_wready[%0d]: got %b/%b want 0/0", i, awready, wready); end
        end
        bready = 1;
        @(negedge clk);
        bready = 0;
        n_chk++; if (bvalid !== 1'b0 || awready !== 1'b1) begin n_fail++; $display("FAIL bp_b_release: got bvalid=%b awready=%b want 0/1", bvalid, awready); end
        do_read(32'h8000_0050, d, rsp, lat, ok);
        n_chk++; if (d !== 32'h13579BDF) begin n_fail++; $display("FAIL bp_wr_data: got %h want 13579bdf", d); end
    endtask
    task automatic test_reset_mid_write();
        logic [31:0] d;
        logic [1:0] rsp;
        int lat;
        bit ok;
        do_write(32'h8000_0060, 32'h11111111, 8'h0F, 0, 0, rsp, lat, ok);
        start_write(32'h8000_0060, 32'h22222222, 8'h0F, 0, 0, ok);
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        n_chk++; if (rvalid !== 1'b0 || bvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valids: got r=%b b=%b want 0/0", rvalid, bvalid); end
        rst_n = 1;
        @(negedge clk);
        n_chk++; if (arready !== 1'b1 || awready !== 1'b1 || bvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got ar=%b aw=%b b=%b want 1/1/0", arready, awready, bvalid); end
        do_read(32'h8000_0060, d, rsp, lat, ok);
        n_chk++; if (d !== 32'h11111111) begin n_fail++; $display("FAIL rstmid_no_commit: got %h want 11111111", d); end
    endtask
    task automatic test_random();
        logic [31:0] pool [16];
        logic [31:0] addr, d, wd;
        logic [1:0] rsp;
        logic [7:0] m;
        int lat, idx, min_lat = 99, max_lat = -1;
        bit ok, inr;
        @(negedge clk);
        sel = 1;
        for (int k = 0; k < 16; k++) begin
            idx = int'($urandom_range(0, 1023));
            pool[k] = BASE + 32'(idx * 4);
            wd = $urandom;
            do_write(pool[k], wd, 8'hFF, 0, 0, rsp, lat, ok);
            mdl[idx] = wd;
            n_chk++; if (!ok || rsp !== 2'b00) begin n_fail++; $display("FAIL rnd_init[%0d]: got ok=%b resp=%b want 1/00", k, ok, rsp); end
        end
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0)
                addr = $urandom_range(0, 1) ? BASE + 32'd4096 + 32'($urandom_range(0, 65535)) : BASE - 32'd1 - 32'($urandom_range(0, 65535));
            else
                addr = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
            inr = addr >= BASE && addr < BASE + 32'd4096;
            idx = inr ? int'((addr - BASE) / 4) : 0;
            if ($urandom_range(0, 1) == 1) begin
                do_read(addr, d, rsp, lat, ok);
                n_chk++; if (!ok) begin n_fail++; $display("FAIL rnd_rd_done[%0d]: got timeout want handshake", t); end
                n_chk++; if (d !== (inr ? mdl[idx] : 32'h0) || rsp !== (inr ? 2'b00 : 2'b10)) begin n_fail++; $display("FAIL rnd_rd[%0d] addr=%h: got %h/%b want %h/%b", t, addr, d, rsp, inr ? mdl[idx] : 32'h0, inr ? 2'b00 : 2'b10); end
                n_chk++; if (lat < R_RD || lat > R_RD + 15) begin n_fail++; $display("FAIL rnd_rd_lat[%0d]: got %0d want %0d..%0d", t, lat, R_RD, R_RD + 15); end
                if (lat < min_lat) min_lat = lat;
                if (lat > max_lat) max_lat = lat;
            end else begin
                wd = $urandom;
                m = 8'($urandom_range(0, 255));
                do_write(addr, wd, m, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), rsp, lat, ok);
                if (inr)
                    for (int b = 0; b < 4; b++)
                        if (m[b]) mdl[idx][8*b +: 8] = wd[8*b +: 8];
                n_chk++; if (!ok || rsp !== (inr ? 2'b00 : 2'b10)) begin n_fail++; $display("FAIL rnd_wr[%0d] addr=%h: got ok=%b resp=%b want 1/%b", t, addr, ok, rsp, inr ? 2'b00 : 2'b10); end
                n_chk++; if (lat < R_WR + 1 || lat > R_WR + 16) begin n_fail++; $display("FAIL rnd_wr_lat[%0d]: got %0d want %0d..%0d", t, lat, R_WR + 1, R_WR + 16); end
            end
        end
        n_chk++; if (max_lat <= min_lat) begin n_fail++; $display("FAIL rnd_jitter: got latency range %0d..%0d want a spread", min_lat, max_lat); end
        @(negedge clk);
        sel = 0;
    endtask
    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_out_of_range();
        test_w_first();
        test_tie();
        test_backpressure();
        test_reset_mid_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
